pulse_pair_check: RTL

Downstream consumer of the wait-counter pulse train. Synchronises the counter's `out` line, measures each high pulse, and validates the expected two-pulse sequence. The sequence is two high pulses of 16384 cycles, separated by 16384 low cycles. It reports pass/fail to the controller that armed the sequence. The block runs in the same clock domain, but it still synchronises its input so it can also monitor a copy of the line routed through a pin.

---
 rtl/pulse_pair_check.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pulse_pair_check.sv
// Synchronises the wait-counter pulse line, measures each high pulse and checks
// for two in-range pulses in a row, reporting done/fail to the arming controller.
module pulse_pair_check #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] MIN_HIGH = 16'h3F00,
  parameter logic [WIDTH-1:0] MAX_HIGH = 16'h40FF,
  parameter logic [WIDTH-1:0] TIMEOUT  = 16'hC000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pulse_in,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       pulse_cnt,
  output logic [WIDTH-1:0] last_width
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HIGH = 3'd1,
    MEAS_HIGH = 3'd2,
    DONE      = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state;
  state_t           next_state;
  logic             s1;
  logic             s2;
  logic             prev;
  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] timer;
  logic [WIDTH-1:0] width;
  logic             in_range;
  logic             timed_out;

  logic [WIDTH-1:0] timer_d;
  logic [WIDTH-1:0] width_d;
  logic [1:0]       cnt_d;
  logic [WIDTH-1:0] last_d;
  logic             busy_d;
  logic             done_d;
  logic             fail_d;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == ALL_ONES) ? v : v + 1'b1;
  endfunction

  assign rise      = s2 & ~prev;
  assign fall      = ~s2 & prev;
  assign timed_out = (timer == TIMEOUT);
  // A saturated width no longer reflects the real pulse length, so it never passes.
  assign in_range  = (width >= MIN_HIGH) && (width <= MAX_HIGH) && (width != ALL_ONES);

  // Input synchroniser and edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= pulse_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort wins over everything; within MEAS_HIGH a fall wins over the timeout.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      next_state = WAIT_HIGH;
        WAIT_HIGH: begin
          if (rise) begin
            next_state = MEAS_HIGH;
          end else if (timed_out) begin
            next_state = FAIL;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            if (!in_range) begin
              next_state = FAIL;
            end else if (pulse_cnt == 2'd1) begin
              next_state = DONE;
            end else begin
              next_state = WAIT_HIGH;
            end
          end else if (timed_out) begin
            next_state = FAIL;
          end
        end
        DONE:      next_state = DONE;
        FAIL:      next_state = FAIL;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Next values for the counters and the registered outputs.
  always_comb begin
    timer_d = timer;
    width_d = width;
    cnt_d   = pulse_cnt;
    last_d  = last_width;
    if (start) begin
      timer_d = '0;
      width_d = '0;
      cnt_d   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          timer_d = '0;
          width_d = '0;
          cnt_d   = 2'd0;
        end
        WAIT_HIGH: begin
          if (rise) begin
            timer_d = '0;
            width_d = {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            timer_d = sat_inc(timer);
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            last_d = width;
            if (in_range) begin
              cnt_d   = pulse_cnt + 2'd1;
              timer_d = '0;
            end
          end else if (timed_out) begin
            last_d = width;
          end else begin
            timer_d = sat_inc(timer);
            if (s2) begin
              width_d = sat_inc(width);
            end
          end
        end
        default: begin
          timer_d = timer;
        end
      endcase
    end
    busy_d = (next_state == WAIT_HIGH) || (next_state == MEAS_HIGH);
    done_d = (next_state == DONE);
    fail_d = (next_state == FAIL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer      <= '0;
      width      <= '0;
      pulse_cnt  <= 2'd0;
      last_width <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      timer      <= timer_d;
      width      <= width_d;
      pulse_cnt  <= cnt_d;
      last_width <= last_d;
      busy       <= busy_d;
      done       <= done_d;
      fail       <= fail_d;
    end
  end

endmodule
